// File: rtl/conv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_ctrl_pkg
// Brief    : Shared types and constants for the convolution window sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package conv_ctrl_pkg;

  // Smallest stage dimension that still yields one complete 3x3 window
  localparam int MIN_DIM         = 3;
  // Deepest feature-memory read latency the tag pipe is sized for
  localparam int MAX_MEM_LATENCY = 4;
  // Width of the drain-phase latency counter
  localparam int DRAIN_CNT_W     = $clog2(MAX_MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Read-side position tag carried alongside the memory read
  typedef struct packed {
    logic       valid;
    logic [7:0] row;
    logic [7:0] col;
  } win_tag_t;

endpackage
`default_nettype wire

// File: rtl/conv_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : conv_tag_pipe
// Brief    : DEPTH-stage register pipe that delays the read position tag so
//            it lines up with the memory read data.
// Revision : 1.0 - initial release
// ============================================================================
module conv_tag_pipe
  import conv_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  win_tag_t i_tag,
  output win_tag_t o_tag
);

  win_tag_t r_pipe [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_first
      // First stage captures the live tag from the read side
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pipe[g] <= '0;
        else        r_pipe[g] <= i_tag;
      end
    end else begin : g_next
      // Later stages shift the tag one cycle further
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pipe[g] <= '0;
        else        r_pipe[g] <= r_pipe[g-1];
      end
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_ctrl
// Brief    : Frame sequencer for the 3x3 window collector. Streams one stage
//            feature map from memory in raster order and flags the cycles in
//            which the collector holds a complete in-image window.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int ADDR_W       = 16,
  parameter int MEM_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_cfg_width,
  input  logic [7:0]        i_cfg_height,
  input  logic [ADDR_W-1:0] i_cfg_base,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_rdata,
  output logic [7:0]        o_pixel_out,
  output logic [7:0]        o_stage_width_out,
  output logic              o_win_valid,
  output logic [7:0]        o_win_row,
  output logic [7:0]        o_win_col,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cfg_err
);

  localparam logic [7:0]             C_MAX_W     = 8'(IMAGE_WIDTH);
  localparam logic [DRAIN_CNT_W-1:0] C_DRAIN_END = DRAIN_CNT_W'(MEM_LATENCY - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [7:0]              r_width;
  logic [7:0]              r_height;
  logic [ADDR_W-1:0]       r_base;
  logic [ADDR_W-1:0]       r_idx;
  logic [7:0]              r_rr;
  logic [7:0]              r_rc;
  logic [DRAIN_CNT_W-1:0]  r_drain_cnt;
  logic [7:0]              r_stage_width;
  logic                    r_done;
  logic                    r_cfg_err;

  logic [31:0]             w_cfg_w32;
  logic [31:0]             w_cfg_h32;
  logic                    w_cfg_ok;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_row_end;
  logic                    w_drain_end;
  win_tag_t                w_tag_in;
  win_tag_t                w_tag_out;
  logic                    w_win_valid;

  assign w_cfg_w32   = {24'd0, i_cfg_width};
  assign w_cfg_h32   = {24'd0, i_cfg_height};
  assign w_cfg_ok    = (w_cfg_w32 >= 32'(MIN_DIM)) && (w_cfg_w32 <= 32'(IMAGE_WIDTH)) &&
                       (w_cfg_h32 >= 32'(MIN_DIM)) && (w_cfg_h32 <= 32'(IMAGE_HEIGHT));
  assign w_accept    = (r_state == IDLE) && i_start && w_cfg_ok;
  assign w_row_end   = (r_rc == r_width - 8'd1);
  assign w_last      = w_row_end && (r_rr == r_height - 8'd1);
  assign w_drain_end = (r_drain_cnt == C_DRAIN_END);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: one pass over the frame, then wait out the read latency
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = RUN;
      RUN:     if (w_last)      w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_end) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Output decode: reads are issued on every RUN cycle, never stalled
  always_comb begin
    o_mem_rd_en = 1'b0;
    o_mem_addr  = '0;
    o_busy      = (r_state != IDLE);
    w_tag_in    = '0;
    if (r_state == RUN) begin
      o_mem_rd_en    = 1'b1;
      o_mem_addr     = r_base + r_idx;
      w_tag_in.valid = 1'b1;
      w_tag_in.row   = r_rr;
      w_tag_in.col   = r_rc;
    end
  end

  // Frame configuration latch and raster read counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width       <= '0;
      r_height      <= '0;
      r_base        <= '0;
      r_idx         <= '0;
      r_rr          <= '0;
      r_rc          <= '0;
      r_stage_width <= C_MAX_W;
    end else if (w_accept) begin
      r_width       <= i_cfg_width;
      r_height      <= i_cfg_height;
      r_base        <= i_cfg_base;
      r_idx         <= '0;
      r_rr          <= '0;
      r_rc          <= '0;
      r_stage_width <= i_cfg_width;
    end else if (r_state == RUN) begin
      r_idx <= r_idx + 1'b1;
      if (w_row_end) begin
        r_rc <= '0;
        r_rr <= r_rr + 8'd1;
      end else begin
        r_rc <= r_rc + 8'd1;
      end
    end
  end

  // Drain counter runs only while waiting for the last reads to return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_drain_cnt <= '0;
    else if (r_state == DRAIN)   r_drain_cnt <= r_drain_cnt + 1'b1;
    else                         r_drain_cnt <= '0;
  end

  // Single-cycle status pulses, one cycle after their cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= (r_state == DRAIN) && w_drain_end;
      r_cfg_err <= (r_state == IDLE) && i_start && !w_cfg_ok;
    end
  end

  conv_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // A window is complete once the newest pixel is at least two rows and two
  // columns into the frame, so edge windows and stale line data are excluded
  assign w_win_valid       = w_tag_out.valid && (w_tag_out.row >= 8'd2) && (w_tag_out.col >= 8'd2);
  assign o_win_valid       = w_win_valid;
  assign o_win_row         = w_win_valid ? (w_tag_out.row - 8'd1) : 8'd0;
  assign o_win_col         = w_win_valid ? (w_tag_out.col - 8'd1) : 8'd0;
  assign o_pixel_out       = i_mem_rdata;
  assign o_stage_width_out = r_stage_width;
  assign o_done            = r_done;
  assign o_cfg_err         = r_cfg_err;

endmodule
`default_nettype wire

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Frame sequencer for the 3x3 window collector in the convolution datapath.
- On a start command it reads one stage feature map from on-chip memory in raster order, one pixel per cycle, and drives the collector's pixel input and stage width.
- It flags the cycles where the collector's nine outputs form a complete in-image 3x3 window and reports the window-centre coordinate to the MAC array.
- The collector has no enable, so this block never stalls mid-frame.

Parameters:
- IMAGE_WIDTH, 128, maximum stage width; must match the collector's line-buffer depth.
- IMAGE_HEIGHT, 128, maximum stage height.
- ADDR_W, 16, feature-memory address width.
- MEM_LATENCY, 1, cycles from mem_rd_en/mem_addr to mem_rdata valid (1..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle frame start request
- cfg_width  in  8  stage width in pixels
- cfg_height  in  8  stage height in pixels
- cfg_base  in  ADDR_W  address of pixel (0,0)
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  8  memory read data
- pixel_out  out  8  to collector pixel_in
- stage_width_out  out  8  to collector stage_width
- win_valid  out  1  collector outputs hold a valid window this cycle
- win_row  out  8  window-centre row
- win_col  out  8  window-centre column
- busy  out  1  frame in progress
- done  out  1  single-cycle frame-complete pulse
- cfg_err  out  1  single-cycle illegal-config pulse

Behaviour:
- Reset values: mem_rd_en=0, mem_addr=0, win_valid=0, win_row=0, win_col=0, busy=0, done=0, cfg_err=0, stage_width_out=IMAGE_WIDTH[7:0].
- pixel_out is combinational from mem_rdata.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: start=1 with a legal config latches width, height and base; goes to RUN; busy=1 from the next cycle. stage_width_out takes the latched width in the same edge and holds it until the next accepted start.
- Illegal config: width<3, width>IMAGE_WIDTH, height<3 or height>IMAGE_HEIGHT. Start is ignored, cfg_err pulses one cycle later, and the FSM stays in IDLE.
- start while busy is ignored; no cfg_err is raised.
- RUN: every cycle mem_rd_en=1, mem_addr=base+idx, with idx incrementing 0..W*H-1. The adder wraps modulo 2^ADDR_W. Read row/column counters (rr, rc) advance rc first, then rr.
- After issuing idx=W*H-1, go to DRAIN.
- DRAIN: mem_rd_en=0; wait MEM_LATENCY cycles; then done=1 for one cycle, busy=0, return to IDLE.
- Tag pipeline: (valid, rr, rc) is delayed MEM_LATENCY cycles so that it is aligned with mem_rdata. Call the delayed values (pv, pr, pc).
- win_valid = pv && pr>=2 && pc>=2, combinational from the aligned tags, in the same cycle the pixel is on pixel_out. This makes the collector's out9 pixel (pr,pc).
- win_row=pr-1, win_col=pc-1 when win_valid=1; both hold 0 when win_valid=0.
- Valid windows per frame: exactly (W-2)*(H-2). No padding; edge windows are suppressed. Stale line-buffer contents from a previous frame never reach a valid window.
- Back-to-back frames: start accepted in the cycle done is high is legal, since the FSM is in IDLE that cycle.
- Reset mid-frame: all state and the tag pipe clear immediately; no done is issued.

Decomposition:
- Shared package conv_ctrl_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - constants MIN_DIM=3 and MAX_MEM_LATENCY=4;
  - the window-valid tag struct {valid, row, col}.
- Sub-module conv_tag_pipe: a parameterised MEM_LATENCY-deep register pipe for the tag struct, reset to all-zero.

Test Plan:
- W=4, H=4, base=0x0100, MEM_LATENCY=1 -> mem_addr 0x0100..0x010F on 16 consecutive cycles; win_valid exactly 4 times with (row,col)=(1,1),(1,2),(2,1),(2,2); done 2 cycles after the last mem_rd_en.
- W=5, H=3, memory holding value=address[7:0], collector attached -> one window per valid cycle, 3 total; at centre (1,1) out1..out9 = 0x00,0x01,0x02,0x05,0x06,0x07,0x0A,0x0B,0x0C.
- cfg_width=2, then cfg_width=200 with IMAGE_WIDTH=128 -> cfg_err pulses once each, busy stays 0, no mem_rd_en.
- start asserted mid-frame with different cfg -> ignored; addresses and window count of the original frame unchanged.
- rst_n low at idx=7 of a 4x4 frame -> all outputs at reset values; a new start completes with 4 windows.
- MEM_LATENCY=3, W=3, H=3, base=0xFFFC -> addresses wrap to 0x0000..0x0004; single window at (1,1) 3 cycles after the 9th address; done 4 cycles after the last read.
